// File: rtl/bram_ctrl.sv
// Valid/ready front end for a single-port synchronous-read BRAM.
// Handles one transaction at a time; partial writes use read-modify-write.
module bram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  input  logic [DATA_WIDTH-1:0]   bram_dout
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;
  logic                  strb_full;
  logic                  strb_zero;

  assign strb_full = &req_strb;
  assign strb_zero = ~|req_strb;
  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign bram_addr = (state == IDLE) ? req_addr : addr_q;

  // Byte merge of the captured write data over the word read back from BRAM.
  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign merged[8*gi +: 8] = strb_q[gi] ? wdata_q[8*gi +: 8] : bram_dout[8*gi +: 8];
  end

  always_comb begin
    state_next = state;
    bram_we    = 1'b0;
    bram_din   = req_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_we) begin
            state_next = RD_WAIT;
          end else if (strb_full) begin
            bram_we    = 1'b1;
            state_next = RESP;
          end else if (strb_zero) begin
            state_next = RESP;
          end else begin
            state_next = RMW;
          end
        end
      end
      RD_WAIT: state_next = RESP;
      RMW: begin
        bram_we    = rst_n;
        bram_din   = merged;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            if (req_we) rsp_rdata <= '0;
          end
        end
        RD_WAIT: rsp_rdata <= bram_dout;
        RMW:     rsp_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl with a behavioural synchronous-read BRAM attached.
module tb_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din, bram_dout;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  bram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we_cyc;   // -1: no BRAM write expected
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int lat = -1;
    int we_cyc = -1;
    logic [31:0] din = '0;
    logic [31:0] rdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb; rsp_ready = 1'b1;
    #1;
    chk($sformatf("txn%0d req_ready", idx), 32'(req_ready), 32'd1);
    if (bram_we) begin we_cyc = 0; din = bram_din; end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = ~v.addr; req_wdata = $urandom; req_strb = 4'hF; req_we = 1'b1;
      #1;
      if (bram_we && we_cyc < 0) begin we_cyc = c; din = bram_din; end
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; break; end
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL txn%0d timeout: got no response, expected latency %0d", idx, v.exp_lat);
    end else begin
      chk($sformatf("txn%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("txn%0d rdata", idx), rdata, v.exp_rdata);
    end
    chk($sformatf("txn%0d we_cycle", idx), 32'(we_cyc), 32'(v.exp_we_cyc));
    if (v.exp_we_cyc >= 0) chk($sformatf("txn%0d bram_din", idx), din, v.exp_din);
    $display("[TB] txn %0d we=%0d addr=%h wdata=%h strb=%h -> rdata=%h lat=%0d we_cyc=%0d",
             idx, v.we, v.addr, v.wdata, v.strb, rdata, lat, we_cyc);
  endtask

  initial begin
    logic [31:0] held;
    int seen;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    vecs[0]  = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0,        1,  0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADBEEF, 2, -1, 32'h0};
    vecs[2]  = '{1'b1, 10'h005, 32'h0000A500, 4'h2, 32'h0,        2,  1, 32'hDEADA5EF};
    vecs[3]  = '{1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADA5EF, 2, -1, 32'h0};
    vecs[4]  = '{1'b1, 10'h005, 32'hFFFFFFFF, 4'h0, 32'h0,        1, -1, 32'h0};
    vecs[5]  = '{1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADA5EF, 2, -1, 32'h0};
    vecs[6]  = '{1'b1, 10'h3FF, 32'h12345678, 4'hF, 32'h0,        1,  0, 32'h12345678};
    vecs[7]  = '{1'b0, 10'h3FF, 32'h0,        4'h0, 32'h12345678, 2, -1, 32'h0};
    vecs[8]  = '{1'b1, 10'h3FF, 32'hAABBCCDD, 4'h9, 32'h0,        2,  1, 32'hAA3456DD};
    vecs[9]  = '{1'b0, 10'h3FF, 32'h0,        4'h0, 32'hAA3456DD, 2, -1, 32'h0};
    vecs[10] = '{1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        2, -1, 32'h0};

    // Reset with a write request pending.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005;
    req_wdata = 32'h55555555; req_strb = 4'hF; rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst bram_we", 32'(bram_we), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);
    $display("[TB] reset sequence done");

    for (int i = 0; i < 11; i++) do_txn(vecs[i], i);

    // Backpressure on a read response.
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h005;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (rsp_valid) seen = 1; else @(negedge clk);
    end
    chk("bp rsp_valid", 32'(seen), 32'd1);
    held = rsp_rdata;
    chk("bp rdata", held, 32'hDEADA5EF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_strb = 4'hF; req_addr = 10'h005; req_wdata = 32'h0;
      #1;
      chk("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp hold rdata", rsp_rdata, held);
      chk("bp hold req_ready", 32'(req_ready), 32'd0);
      chk("bp hold bram_we", 32'(bram_we), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp done rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp done req_ready", 32'(req_ready), 32'd1);
    $display("[TB] backpressure read rdata=%h", held);

    // Reset during the RMW cycle of a partial write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = 32'h00000011; req_strb = 4'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rmw-rst bram_we", 32'(bram_we), 32'd0);
    chk("rmw-rst rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset during RMW done");
    do_txn('{1'b0, 10'h005, 32'h0, 4'h0, 32'hDEADA5EF, 2, -1, 32'h0}, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
